// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the registered N-channel stream mux.
package stream_mux_pkg;

  localparam int NCH_DEF = 5;
  localparam int W_DEF   = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ch_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rr_next_pick.sv
// Rotating-priority finder: nearest valid channel strictly after cur_i, wrapping.
// Only built with STREAM_MUX_RR_EN defined.
`ifdef STREAM_MUX_RR_EN
module rr_next_pick
  import stream_mux_pkg::*;
#(
  parameter  int NCH  = NCH_DEF,
  localparam int SELW = clog2(NCH)
) (
  input  logic [NCH-1:0]  vld_i,
  input  logic [SELW-1:0] cur_i,
  output logic [SELW-1:0] nxt_o,
  output logic            found_o
);

  int best;
  int d;

  // Distance NCH means "same channel", which is never a candidate.
  always_comb begin
    nxt_o   = cur_i;
    found_o = 1'b0;
    best    = NCH;
    d       = 0;
    for (int j = 0; j < NCH; j++) begin
      d = j - int'(cur_i);
      if (d <= 0) d = d + NCH;
      if (vld_i[j] && (d < NCH) && (d < best)) begin
        best    = d;
        nxt_o   = SELW'(j);
        found_o = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/stream_mux_n.sv
// Registered NCH-channel W-bit stream mux, 1-cycle latency, held select + sticky illegal-select flag.
// Optional round-robin source stepping via STREAM_MUX_RR_EN (adds rr_mode input).
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter  int NCH  = NCH_DEF,
  parameter  int W    = W_DEF,
  localparam int SELW = clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SELW-1:0]   sel,
  input  logic              sel_load,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   cur_sel,
  output logic              sel_err,
`ifdef STREAM_MUX_RR_EN
  input  logic              rr_mode,
`endif
  input  logic              err_clr
);

  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic            sel_err_q, sel_err_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;

  logic            take_rdy;
  logic            sel_vld;
  logic [W-1:0]    sel_dat;
  logic            accept;
  logic            rr_on;
  logic            sel_legal;
  logic            load_ok;
  logic            load_bad;

  // Output slot can take a word when empty or being drained this cycle.
  assign take_rdy = !out_valid_q || out_ready;

  always_comb begin
    sel_vld  = 1'b0;
    sel_dat  = '0;
    in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cur_sel_q == SELW'(k)) begin
        sel_vld     = in_valid[k];
        sel_dat     = in_data[ch_lo(k, W) +: W];
        in_ready[k] = take_rdy;
      end
    end
  end

  assign accept    = sel_vld && take_rdy;
  assign sel_legal = ({1'b0, sel} < NCH_L);

`ifdef STREAM_MUX_RR_EN
  logic [SELW-1:0] rr_nxt;
  logic            rr_found;

  rr_next_pick #(.NCH(NCH)) u_rr_next_pick (
    .vld_i   (in_valid),
    .cur_i   (cur_sel_q),
    .nxt_o   (rr_nxt),
    .found_o (rr_found)
  );

  assign rr_on = rr_mode;
`else
  assign rr_on = 1'b0;
`endif

  assign load_ok  = sel_load && !rr_on && sel_legal;
  assign load_bad = sel_load && !rr_on && !sel_legal;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = sel_dat;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    cur_sel_d = cur_sel_q;
    if (load_ok) cur_sel_d = sel;
`ifdef STREAM_MUX_RR_EN
    // Step after a transfer, or hop off an idle channel without transferring.
    if (rr_on && rr_found && (accept || !sel_vld)) cur_sel_d = rr_nxt;
`endif

    sel_err_d = sel_err_q;
    if (load_bad)     sel_err_d = 1'b1;
    else if (err_clr) sel_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cur_sel_q   <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cur_sel_q   <= cur_sel_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign cur_sel   = cur_sel_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n (NCH=5, W=8); round-robin section needs STREAM_MUX_RR_EN.
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel;
  logic        sel_load;
  logic [39:0] in_data;
  logic [4:0]  in_valid;
  logic [4:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  cur_sel;
  logic        sel_err;
  logic        err_clr;
`ifdef STREAM_MUX_RR_EN
  logic        rr_mode;
  logic [7:0]  rr_q[$];
  logic [7:0]  rr_exp [6];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic       sb_en = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] sb_exp [6];

  stream_mux_n #(.NCH(5), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .sel_load  (sel_load),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_sel   (cur_sel),
    .sel_err   (sel_err),
`ifdef STREAM_MUX_RR_EN
    .rr_mode   (rr_mode),
`endif
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sb_en && out_valid && out_ready) rx_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input logic [7:0] v);
    in_data[k*8 +: 8] = v;
  endtask

  initial begin
    sb_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99, 8'hA5};
    rst_n = 1'b0; sel = '0; sel_load = 1'b0; in_data = '0; in_valid = '0;
    out_ready = 1'b0; err_clr = 1'b0;
`ifdef STREAM_MUX_RR_EN
    rr_mode = 1'b0;
    rr_exp  = '{8'h01, 8'h03, 8'h04, 8'h01, 8'h03, 8'h04};
`endif
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cur_sel", cur_sel, 0);
    check("rst_sel_err", sel_err, 0);
    check("rst_in_ready", in_ready, 5'b00001);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_en = 1'b1;

    // ch0 streams three words back to back
    out_ready = 1'b1; in_valid = 5'b00001; put(0, 8'h11);
    #1 check("s0_in_ready", in_ready, 5'b00001);
    tick(); check("s1_valid", out_valid, 1); check("s1_data", out_data, 8'h11);
    put(0, 8'h22); #1 check("s1_in_ready", in_ready, 5'b00001);
    tick(); check("s2_data", out_data, 8'h22);
    put(0, 8'h33);
    tick(); check("s3_data", out_data, 8'h33);
    in_valid = 5'b00000;
    tick(); check("s4_valid", out_valid, 0); check("s4_data_hold", out_data, 8'h33);

    // select switch while ch0 still sending
    put(0, 8'h44); put(3, 8'h99); in_valid = 5'b01001; sel = 3'd3; sel_load = 1'b1;
    #1 check("ld_cur_old", cur_sel, 0); check("ld_rdy_old", in_ready, 5'b00001);
    tick(); sel_load = 1'b0;
    check("ld_data_old_ch", out_data, 8'h44); check("ld_cur_new", cur_sel, 3);
    #1 check("ld_rdy_new", in_ready, 5'b01000);
    tick(); check("ld_data_new_ch", out_data, 8'h99); check("ld_valid", out_valid, 1);

    // four-cycle downstream stall
    put(3, 8'hA5); out_ready = 1'b0;
    #1 check("st_rdy0", in_ready, 5'b00000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_data_hold", out_data, 8'h99);
      check("st_valid_hold", out_valid, 1);
      check("st_rdy", in_ready, 5'b00000);
    end
    out_ready = 1'b1;
    #1 check("st_release_rdy", in_ready, 5'b01000);
    tick(); check("st_next_data", out_data, 8'hA5);
    in_valid = 5'b00000;
    tick(); check("st_drained", out_valid, 0);
    sb_en = 1'b0;
    check("sb_count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rx_q.size()) check("sb_word", rx_q[i], sb_exp[i]);
      else check("sb_word_missing", 0, sb_exp[i]);
    end

    // illegal selects and error clear
    sel = 3'd6; sel_load = 1'b1;
    tick(); check("ill6_cur", cur_sel, 3); check("ill6_err", sel_err, 1);
    sel = 3'd7; err_clr = 1'b1;
    tick(); check("ill7_set_wins", sel_err, 1); check("ill7_cur", cur_sel, 3);
    sel_load = 1'b0;
    tick(); check("clr_err", sel_err, 0);
    err_clr = 1'b0; sel = 3'd4; sel_load = 1'b1;
    tick(); check("ld4_cur", cur_sel, 4); check("ld4_err", sel_err, 0);
    sel = 3'd5;
    tick(); check("ill5_cur", cur_sel, 4); check("ill5_err", sel_err, 1);

    // asynchronous reset with a word held in the output
    sel_load = 1'b0; out_ready = 1'b0; in_valid = 5'b10000; put(4, 8'h5A);
    tick(); check("pre_rst_valid", out_valid, 1); check("pre_rst_data", out_data, 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_cur", cur_sel, 0);
    check("arst_err", sel_err, 0);
    check("arst_data", out_data, 0);
    in_valid = 5'b00000;

`ifdef STREAM_MUX_RR_EN
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 5'b11010; put(1, 8'h01); put(3, 8'h03); put(4, 8'h04);
    out_ready = 1'b1; rr_mode = 1'b1; sel = 3'd2; sel_load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) rr_q.push_back(out_data);
    end
    check("rr_count_ok", rr_q.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
      if (i < rr_q.size()) check("rr_order", rr_q[i], rr_exp[i]);
      else check("rr_order_missing", 0, rr_exp[i]);
    end
    check("rr_no_err", sel_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
